// File: rtl/load_store_unit.sv
// RV32I load/store unit: decodes the access, drives a single-outstanding data-memory
// request and returns the aligned, extended load result with a one-cycle done pulse.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] TMO = 32'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state;
  logic [2:0]  op_funct3;
  logic [1:0]  op_off;
  logic        op_store;
  logic [31:0] wait_cnt;

  logic        req_legal;
  logic        req_misaligned;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;

  // Decode of the incoming request; only meaningful in the cycle start is accepted.
  always_comb begin
    req_legal      = 1'b0;
    req_misaligned = 1'b0;
    req_be         = 4'b0000;
    req_wdata      = wdata;
    case (funct3[1:0])
      2'b00: begin
        req_be    = 4'b0001 << addr[1:0];
        req_wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        req_be         = addr[1] ? 4'b1100 : 4'b0011;
        req_wdata      = {2{wdata[15:0]}};
        req_misaligned = addr[0];
      end
      2'b10: begin
        req_be         = 4'b1111;
        req_misaligned = |addr[1:0];
      end
      default: ;
    endcase
    case (funct3)
      3'b000, 3'b001, 3'b010: req_legal = 1'b1;
      3'b100, 3'b101:         req_legal = !is_store;
      default:                req_legal = 1'b0;
    endcase
  end

  function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] off,
                                          input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  extract = {{24{b[7]}}, b};
      3'b001:  extract = {{16{h[15]}}, h};
      3'b100:  extract = {24'b0, b};
      3'b101:  extract = {16'b0, h};
      default: extract = w;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
      rdata     <= 32'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'b0;
      mem_be    <= 4'b0;
      mem_wdata <= 32'b0;
      wait_cnt  <= 32'b0;
      op_funct3 <= 3'b0;
      op_off    <= 2'b0;
      op_store  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            op_funct3 <= funct3;
            op_off    <= addr[1:0];
            op_store  <= is_store;
            if (req_legal && !req_misaligned) begin
              state     <= ACCESS;
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_be    <= req_be;
              mem_wdata <= req_wdata;
              wait_cnt  <= 32'b0;
            end else begin
              state <= DONE;
              done  <= 1'b1;
              fault <= 1'b1;
              rdata <= 32'b0;
            end
          end
        end
        // An ack in the same cycle the timeout would fire still completes the access.
        ACCESS: begin
          if (mem_ack) begin
            state   <= DONE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            done    <= 1'b1;
            fault   <= 1'b0;
            if (!op_store) rdata <= extract(op_funct3, op_off, mem_rdata);
          end else if (TMO != 32'b0 && wait_cnt + 32'd1 == TMO) begin
            state   <= DONE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            done    <= 1'b1;
            fault   <= 1'b1;
            rdata   <= 32'b0;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          fault <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a scoreboard of expected rdata/fault per request.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        fault;
  logic [31:0] rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  typedef struct packed {
    logic [31:0] rdata;
    logic        fault;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   reqCycles;
  int   cyc;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .fault(fault), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives a one-cycle start and records what the eventual done must report.
  task automatic applyStimulus(input logic st, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd, input logic [31:0] expRdata,
                               input logic expFault);
    start    = 1'b1;
    is_store = st;
    funct3   = f3;
    addr     = a;
    wdata    = wd;
    sb.push_back('{rdata: expRdata, fault: expFault});
    tick();
    start = 1'b0;
  endtask

  task automatic scoreCheck(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL %s scoreboard empty observed=done expected=none", tag);
    end else begin
      e = sb.pop_front();
      checkOutput({tag, "_done"}, 32'(done), 32'd1);
      checkOutput({tag, "_rdata"}, rdata, e.rdata);
      checkOutput({tag, "_fault"}, 32'(fault), 32'(e.fault));
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; is_store = 1'b0; funct3 = 3'b0;
    addr = 32'b0; wdata = 32'b0; mem_ack = 1'b0; mem_rdata = 32'b0;
    tick();
    tick();
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_req", 32'(mem_req), 32'd0);
    checkOutput("rst_rdata", rdata, 32'd0);
    checkOutput("rst_addr", mem_addr, 32'd0);
    rst_n = 1'b1;

    // LB with ack in the first ACCESS cycle
    applyStimulus(1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'hFFFF_FF80, 1'b0);
    checkOutput("lb_req", 32'(mem_req), 32'd1);
    checkOutput("lb_we", 32'(mem_we), 32'd0);
    checkOutput("lb_addr", mem_addr, 32'h0000_1000);
    checkOutput("lb_be", 32'(mem_be), 32'b1000);
    checkOutput("lb_busy", 32'(busy), 32'd1);
    checkOutput("lb_nodone", 32'(done), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h80FF_1234;
    tick();
    mem_ack = 1'b0;
    scoreCheck("lb");
    checkOutput("lb_req_off", 32'(mem_req), 32'd0);
    tick();
    checkOutput("lb_idle_busy", 32'(busy), 32'd0);
    checkOutput("lb_idle_done", 32'(done), 32'd0);

    // SH with three wait cycles, ack on the fourth request cycle
    applyStimulus(1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'hFFFF_FF80, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("sh_req", 32'(mem_req), 32'd1);
      checkOutput("sh_we", 32'(mem_we), 32'd1);
      checkOutput("sh_be", 32'(mem_be), 32'b1100);
      checkOutput("sh_wdata", mem_wdata, 32'hABCD_ABCD);
      checkOutput("sh_addr", mem_addr, 32'h0000_2000);
      if (i == 3) mem_ack = 1'b1;
      tick();
    end
    mem_ack = 1'b0;
    scoreCheck("sh");
    tick();

    // Misaligned LW and illegal store funct3 fault without a memory request
    applyStimulus(1'b0, 3'b010, 32'h0000_3001, 32'h0, 32'h0, 1'b1);
    checkOutput("lw_mis_req", 32'(mem_req), 32'd0);
    scoreCheck("lw_mis");
    tick();
    checkOutput("lw_mis_after", 32'(done), 32'd0);
    applyStimulus(1'b1, 3'b100, 32'h0000_3000, 32'h5555_5555, 32'h0, 1'b1);
    checkOutput("st_ill_req", 32'(mem_req), 32'd0);
    scoreCheck("st_ill");
    tick();

    // LHU that never gets an ack times out
    applyStimulus(1'b0, 3'b101, 32'h0000_4000, 32'h0, 32'h0, 1'b1);
    reqCycles = 0;
    cyc = 0;
    while (!done && cyc < 20) begin
      if (mem_req) reqCycles++;
      tick();
      cyc++;
    end
    checkOutput("tmo_reached", 32'(cyc < 20), 32'd1);
    checkOutput("tmo_req_drop", 32'(mem_req), 32'd0);
    checkOutput("tmo_had_req", 32'(reqCycles > 0), 32'd1);
    scoreCheck("tmo");
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    tick();
    mem_ack = 1'b0;
    checkOutput("stray_done", 32'(done), 32'd0);
    checkOutput("stray_busy", 32'(busy), 32'd0);
    checkOutput("stray_rdata", rdata, 32'd0);

    // start during ACCESS is ignored
    applyStimulus(1'b0, 3'b010, 32'h0000_6000, 32'h0, 32'hDEAD_BEEF, 1'b0);
    start = 1'b1; addr = 32'h0000_7004; funct3 = 3'b000;
    tick();
    start = 1'b0;
    checkOutput("ign_addr", mem_addr, 32'h0000_6000);
    checkOutput("ign_be", 32'(mem_be), 32'b1111);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ack = 1'b0;
    scoreCheck("ign");
    tick();
    tick();
    checkOutput("ign_no_extra", 32'(done), 32'd0);
    checkOutput("ign_idle", 32'(busy), 32'd0);

    // Reset in the middle of an access aborts it without a done pulse
    applyStimulus(1'b0, 3'b010, 32'h0000_8000, 32'h0, 32'h0, 1'b0);
    void'(sb.pop_back());
    checkOutput("abort_req_on", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_req", 32'(mem_req), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    tick();
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_rdata", rdata, 32'd0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 3'b100, 32'h0000_5001, 32'h0, 32'h0000_009A, 1'b0);
    checkOutput("lbu_req", 32'(mem_req), 32'd1);
    checkOutput("lbu_be", 32'(mem_be), 32'b0010);
    mem_ack = 1'b1; mem_rdata = 32'h0000_9A00;
    tick();
    mem_ack = 1'b0;
    scoreCheck("lbu");
    tick();

    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: max cycles to wait for mem_ack; 0 disables timeout.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  one-cycle request; accepted only when busy=0.
REQ-005 is_store  input  1  1=store, 0=load; sampled with start.
REQ-006 funct3  input  3  access type (RV32I load/store funct3); sampled with start.
REQ-007 addr  input  32  effective byte address (execute-stage Out); sampled with start.
REQ-008 wdata  input  32  store data (rs2); sampled with start.
REQ-009 busy  output  1  high from cycle after accepted start until done cycle inclusive.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 fault  output  1  valid with done: misaligned, illegal funct3 or timeout.
REQ-012 rdata  output  32  load result, valid with done; held until next done.
REQ-013 mem_req  output  1  data-memory request.
REQ-014 mem_we  output  1  write enable for mem_req.
REQ-015 mem_addr  output  32  word address {addr[31:2],2'b00}.
REQ-016 mem_be  output  4  byte enables.
REQ-017 mem_wdata  output  32  lane-replicated store data.
REQ-018 mem_ack  input  1  memory accepted/completed access this cycle.
REQ-019 mem_rdata  input  32  read word, valid when mem_ack=1 on a load.

Function
REQ-020 FSM states IDLE, ACCESS, DONE; IDLE->ACCESS on start with legal aligned op; IDLE->DONE on start with fault; ACCESS->DONE on mem_ack or timeout; DONE->IDLE unconditionally.
REQ-021 start while busy=1 SHALL be ignored, no side effects.
REQ-022 Legal loads funct3 000,001,010,100,101; legal stores 000,001,010; anything else SHALL set fault.
REQ-023 Misaligned: halfword with addr[0]=1, word with addr[1:0]!=00 SHALL set fault.
REQ-024 Fault path: no mem_req issued, done and fault asserted in cycle after start, rdata=0.
REQ-025 mem_req SHALL be high every cycle in ACCESS; mem_we/mem_addr/mem_be/mem_wdata SHALL be registered and stable while mem_req=1.
REQ-026 mem_ack SHALL be sampled only in ACCESS; ack in first ACCESS cycle permitted (minimum start-to-done latency 2 cycles).
REQ-027 Byte: mem_be=4'b0001<<addr[1:0], mem_wdata={4{wdata[7:0]}}.
REQ-028 Halfword: mem_be=0011 if addr[1]=0 else 1100, mem_wdata={2{wdata[15:0]}}.
REQ-029 Word: mem_be=1111, mem_wdata=wdata; loads drive same mem_be as stores.
REQ-030 LB/LH SHALL sign-extend, LBU/LHU zero-extend the lane selected by addr[1:0]; LW passes word.
REQ-031 Stores SHALL leave rdata unchanged.
REQ-032 Wait counter SHALL clear on entering ACCESS; if TIMEOUT_CYCLES>0 and counter reaches TIMEOUT_CYCLES without ack, go to DONE with fault=1, mem_req dropped.
REQ-033 mem_ack outside ACCESS SHALL be ignored.
REQ-034 fault SHALL be 0 whenever done=0.

Reset
REQ-035 rst_n=0 SHALL immediately force state IDLE and busy, done, fault, mem_req, mem_we to 0; rdata, mem_addr, mem_be, mem_wdata, counter to 0.
REQ-036 Reset mid-ACCESS SHALL drop mem_req asynchronously; no done pulse for aborted access.
REQ-037 First start accepted on first rising edge with rst_n=1.

Verification
REQ-038 LB addr=0x1003, mem_rdata=0x80FF_1234, ack on first ACCESS cycle -> mem_addr=0x1000, mem_be=1000, done 2 cycles after start, rdata=0xFFFF_FF80, fault=0.
REQ-039 SH addr=0x2002, wdata=0x1234_ABCD, ack after 3 wait cycles -> mem_we=1, mem_be=1100, mem_wdata=0xABCD_ABCD stable all 4 req cycles, done next cycle.
REQ-040 LW addr=0x3001 -> no mem_req, done+fault 1 cycle after start; store funct3=100 -> same.
REQ-041 LHU addr=0x4000, mem_ack never, TIMEOUT_CYCLES=4 -> mem_req drops, done+fault after timeout; stray ack afterwards ignored.
REQ-042 start asserted during ACCESS with different addr -> ignored, mem_addr unchanged.
REQ-043 rst_n pulled low mid-ACCESS -> mem_req/busy 0 same cycle, no done; new LBU addr=0x5001, mem_rdata=0x0000_9A00 after reset -> rdata=0x0000_009A.
